alu_seq: RTL

Parametrised, handshaked successor to the team's 2-bit-opcode combinational ALU. It keeps the ADD/SUB/AND/OR encodings and NZCV flag convention, and adds XOR, logical shifts and an iterative shift-add multiply. Operands enter through a valid/ready port. Result and flags are registered and held on a valid/ready output port. It sits between the datapath register file and the writeback stage and stalls upstream while a multiply is in progress.

---
 rtl/alu_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with NZCV flags, logical shifts and an iterative shift-add multiply.
// Result and flags are registered and held until the consumer takes them.
//
// state | meaning
// IDLE  | ready for a new operation
// BUSY  | shift-add multiply in progress, upstream stalled
// DONE  | result/flags valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  logic               sub;
  logic [WIDTH-1:0]   b_op;
  logic [WIDTH:0]     sum;
  logic [SHW:0]       shamt_x;
  logic               shift_big;
  logic [WIDTH:0]     shl_ext, shr_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [2*WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_c;
  logic               mul_last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle ops are evaluated straight off the inputs at acceptance.
  always_comb begin
    sub       = (op == OP_SUB);
    b_op      = sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    shamt_x   = {1'b0, b[SHW-1:0]};
    shift_big = (shamt_x >= (SHW+1)'(WIDTH));
    // One spare bit on each side captures the last bit shifted out.
    shl_ext   = {1'b0, a} << b[SHW-1:0];
    shr_ext   = {a, 1'b0} >> b[SHW-1:0];
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        if (!shift_big) begin
          alu_res = shl_ext[WIDTH-1:0];
          alu_c   = shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shift_big) begin
          alu_res = shr_ext[WIDTH:1];
          alu_c   = shr_ext[0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;
    mul_res     = mul_acc_nxt[WIDTH-1:0];
    mul_c       = |mul_acc_nxt[2*WIDTH-1:WIDTH];
    mul_last    = (cnt == SHW'(WIDTH-1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (op == OP_MUL) ? BUSY : DONE;
      BUSY:    if (mul_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      result    <= '0;
      alu_flags <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              cnt    <= '0;
            end else begin
              result    <= alu_res;
              alu_flags <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
          end
        end
        BUSY: begin
          acc    <= mul_acc_nxt;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + SHW'(1);
          if (mul_last) begin
            result    <= mul_res;
            alu_flags <= {mul_res[WIDTH-1], (mul_res == '0), mul_c, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
